// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: owns the shared account balance.
// Accepts deposit, withdraw and inquiry requests from NUM_REQ requesters,
// arbitrates between them round-robin, and runs one transaction at a time
// through a req/grant/done handshake.
module atm_ledger_arbiter #(
    parameter int unsigned      NUM_REQ      = 2,
    parameter int unsigned      AMT_W        = 11,
    parameter int unsigned      BAL_W        = 33,
    parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(1000000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     op,
    input  logic [AMT_W*NUM_REQ-1:0] amt,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     done,
    output logic [1:0]               status,
    output logic [BAL_W-1:0]         balance_out,
    output logic                     busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_DEPOSIT  = 2'b01;
    localparam logic [1:0] OP_WITHDRAW = 2'b10;

    localparam logic [1:0] STAT_OK   = 2'd0;
    localparam logic [1:0] STAT_NSF  = 2'd1;
    localparam logic [1:0] STAT_ZERO = 2'd2;
    localparam logic [1:0] STAT_OVF  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWait
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic [1:0]         op_q;
    logic [AMT_W-1:0]   amt_q;
    logic [BAL_W-1:0]   balance_q;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [1:0]         pick_op;
    logic [AMT_W-1:0]   pick_amt;
    logic [PTR_W-1:0]   ptr_next;

    logic [BAL_W-1:0]   amt_ext;
    logic [BAL_W:0]     sum;
    logic [BAL_W-1:0]   commit_bal;
    logic [1:0]         commit_status;

    // Round-robin pick: first requester at or after ptr_q with req high.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot = NUM_REQ'(1) << pick_idx;
        pick_op     = op[2*pick_idx +: 2];
        pick_amt    = amt[AMT_W*pick_idx +: AMT_W];
        ptr_next    = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
    end

    // Commit result of the latched op; the extra sum bit flags overflow.
    always_comb begin
        amt_ext       = BAL_W'(amt_q);
        sum           = {1'b0, balance_q} + {1'b0, amt_ext};
        commit_bal    = balance_q;
        commit_status = STAT_OK;
        case (op_q)
            OP_DEPOSIT: begin
                if (amt_q == '0) begin
                    commit_status = STAT_ZERO;
                end else if (sum[BAL_W]) begin
                    commit_status = STAT_OVF;
                end else begin
                    commit_bal = sum[BAL_W-1:0];
                end
            end
            OP_WITHDRAW: begin
                if (amt_q == '0) begin
                    commit_status = STAT_ZERO;
                end else if (amt_ext > balance_q) begin
                    commit_status = STAT_NSF;
                end else begin
                    commit_bal = balance_q - amt_ext;
                end
            end
            // Inquiry and the reserved code leave the balance alone.
            default: begin
                commit_status = STAT_OK;
            end
        endcase
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            op_q        <= 2'b00;
            amt_q       <= '0;
            balance_q   <= INIT_BALANCE;
            grant       <= '0;
            done        <= 1'b0;
            status      <= STAT_OK;
            balance_out <= INIT_BALANCE;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant   <= pick_onehot;
                        win_q   <= pick_idx;
                        op_q    <= pick_op;
                        amt_q   <= pick_amt;
                        busy    <= 1'b1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    balance_q   <= commit_bal;
                    balance_out <= commit_bal;
                    status      <= commit_status;
                    done        <= 1'b1;
                    state_q     <= StWait;
                end
                StWait: begin
                    // Hold the grant until the winner releases its request.
                    if (!req[win_q]) begin
                        grant   <= '0;
                        ptr_q   <= ptr_next;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Structural invariants of the handshake.
    a_grant_onehot: assert property (@(posedge clk) $onehot0(grant));
    a_done_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Testbench for atm_ledger_arbiter: directed table, hand sequences and a
// randomized run against a behavioural ledger model.
module tb_atm_ledger_arbiter;

    localparam longint MAXB = (64'd1 << 33) - 1;

    logic        clk;
    logic        rst;
    logic [1:0]  req   [3];
    logic [3:0]  op    [3];
    logic [21:0] amt   [3];
    logic [1:0]  grant [3];
    logic        done  [3];
    logic [1:0]  status[3];
    logic [32:0] bal   [3];
    logic        busy  [3];

    int errors = 0;
    int checks = 0;

    atm_ledger_arbiter #(.NUM_REQ(2), .AMT_W(11), .BAL_W(33),
                         .INIT_BALANCE(33'd1000000)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .op(op[0]), .amt(amt[0]),
        .grant(grant[0]), .done(done[0]), .status(status[0]),
        .balance_out(bal[0]), .busy(busy[0]));

    atm_ledger_arbiter #(.NUM_REQ(2), .AMT_W(11), .BAL_W(33),
                         .INIT_BALANCE(33'd1000)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .op(op[1]), .amt(amt[1]),
        .grant(grant[1]), .done(done[1]), .status(status[1]),
        .balance_out(bal[1]), .busy(busy[1]));

    atm_ledger_arbiter #(.NUM_REQ(2), .AMT_W(11), .BAL_W(33),
                         .INIT_BALANCE(33'h1_FFFF_FFFA)) dut2 (
        .clk(clk), .rst(rst), .req(req[2]), .op(op[2]), .amt(amt[2]),
        .grant(grant[2]), .done(done[2]), .status(status[2]),
        .balance_out(bal[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         r;
        logic [1:0] o;
        int         a;
        int         es;
        longint     eb;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            op[d]  = '0;
            amt[d] = '0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    // Ledger rules computed directly from the operation definitions.
    task automatic model_apply(input logic [1:0] o, input int a,
                               inout longint b, output int st);
        st = 0;
        if (o == 2'b01) begin
            if (a == 0) st = 2;
            else if (b + a > MAXB) st = 3;
            else b = b + a;
        end else if (o == 2'b10) begin
            if (a == 0) st = 2;
            else if (a > b) st = 1;
            else b = b - a;
        end
    endtask

    // One lone-requester transaction with cycle-exact handshake checks.
    task automatic run_single(input int d, input int r, input logic [1:0] o,
                              input int a, input int es, input longint eb);
        op[d][2*r +: 2]   = o;
        amt[d][11*r +: 11] = 11'(a);
        req[d][r]         = 1'b1;
        step();
        check($sformatf("d%0d grant", d), grant[d], longint'(1) << r);
        check($sformatf("d%0d busy", d), busy[d], 1);
        check($sformatf("d%0d done_early", d), done[d], 0);
        step();
        check($sformatf("d%0d done", d), done[d], 1);
        check($sformatf("d%0d status", d), status[d], es);
        check($sformatf("d%0d balance", d), bal[d], eb);
        req[d][r] = 1'b0;
        step();
        check($sformatf("d%0d done_pulse", d), done[d], 0);
        check($sformatf("d%0d grant_clear", d), grant[d], 0);
        check($sformatf("d%0d idle", d), busy[d], 0);
    endtask

    initial begin
        longint mbal;
        int     mptr;
        int     mst;
        int     mask;
        int     w;
        logic [1:0] rop [2];
        int     ramt[2];

        vecs[0]  = '{0, 0, 2'b00, 0,    0, 1000000};
        vecs[1]  = '{0, 0, 2'b01, 500,  0, 1000500};
        vecs[2]  = '{0, 0, 2'b10, 2000, 0, 998500};
        vecs[3]  = '{0, 1, 2'b11, 7,    0, 998500};
        vecs[4]  = '{1, 0, 2'b10, 1500, 1, 1000};
        vecs[5]  = '{1, 0, 2'b01, 0,    2, 1000};
        vecs[6]  = '{1, 1, 2'b10, 0,    2, 1000};
        vecs[7]  = '{1, 0, 2'b10, 1000, 0, 0};
        vecs[8]  = '{1, 0, 2'b10, 1,    1, 0};
        vecs[9]  = '{2, 0, 2'b01, 10,   3, MAXB - 5};
        vecs[10] = '{2, 0, 2'b01, 5,    0, MAXB};
        vecs[11] = '{2, 0, 2'b01, 1,    3, MAXB};
        vecs[12] = '{2, 1, 2'b10, 2047, 0, MAXB - 2047};

        rst = 1'b1;
        do_reset();
        step();
        check("reset bal0", bal[0], 1000000);
        check("reset bal1", bal[1], 1000);
        check("reset bal2", bal[2], MAXB - 5);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset grant%0d", d), grant[d], 0);
            check($sformatf("reset done%0d", d), done[d], 0);
            check($sformatf("reset busy%0d", d), busy[d], 0);
            check($sformatf("reset status%0d", d), status[d], 0);
        end

        foreach (vecs[i])
            run_single(vecs[i].d, vecs[i].r, vecs[i].o, vecs[i].a, vecs[i].es, vecs[i].eb);

        // Simultaneous requests from reset: grants rotate 01, 10, 01.
        do_reset();
        op[0] = 4'b0000;
        req[0] = 2'b11;
        step();
        check("sim grant A", grant[0], 1);
        step();
        check("sim done A", done[0], 1);
        req[0][0] = 1'b0;
        step();
        check("sim gap A", grant[0], 0);
        step();
        check("sim grant B", grant[0], 2);
        req[0][0] = 1'b1;
        step();
        check("sim done B", done[0], 1);
        step();
        check("sim hold B", grant[0], 2);
        check("sim done once", done[0], 0);
        req[0][1] = 1'b0;
        step();
        check("sim gap B", grant[0], 0);
        step();
        check("sim grant C", grant[0], 1);
        step();
        check("sim done C", done[0], 1);
        req[0][0] = 1'b0;
        step();

        // Reset during EXEC discards the pending withdraw.
        do_reset();
        run_single(0, 0, 2'b01, 100, 0, 1000100);
        op[0][1:0]  = 2'b10;
        amt[0][10:0] = 11'd300;
        req[0][0]   = 1'b1;
        step();
        check("rstexec grant", grant[0], 1);
        rst = 1'b1;
        step();
        check("rstexec done", done[0], 0);
        check("rstexec grant0", grant[0], 0);
        check("rstexec bal", bal[0], 1000000);
        check("rstexec busy", busy[0], 0);
        rst = 1'b0;
        req[0] = '0;
        step();
        run_single(0, 0, 2'b00, 0, 0, 1000000);

        // Request dropped during EXEC still commits.
        op[0][3:2]    = 2'b01;
        amt[0][21:11] = 11'd25;
        req[0][1]     = 1'b1;
        step();
        check("drop grant", grant[0], 2);
        req[0][1] = 1'b0;
        step();
        check("drop done", done[0], 1);
        check("drop bal", bal[0], 1000025);
        step();
        check("drop idle", grant[0], 0);
        check("drop done once", done[0], 0);

        // Randomized contention against the behavioural model.
        do_reset();
        mbal = 1000000;
        mptr = 0;
        for (int round = 0; round < 80; round++) begin
            mask = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                rop[r]  = 2'($urandom_range(0, 3));
                ramt[r] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
                op[0][2*r +: 2]    = rop[r];
                amt[0][11*r +: 11] = 11'(ramt[r]);
                req[0][r]          = mask[r];
            end
            while (mask != 0) begin
                step();
                w = mask[mptr] ? mptr : 1 - mptr;
                check("rnd grant", grant[0], longint'(1) << w);
                // Inputs after grant must not affect the committed transaction.
                op[0][2*w +: 2]    = 2'($urandom_range(0, 3));
                amt[0][11*w +: 11] = 11'($urandom_range(0, 2047));
                step();
                model_apply(rop[w], ramt[w], mbal, mst);
                check("rnd done", done[0], 1);
                check("rnd status", status[0], mst);
                check("rnd balance", bal[0], mbal);
                req[0][w] = 1'b0;
                mask[w]   = 1'b0;
                mptr      = (w + 1) % 2;
                step();
                check("rnd release", grant[0], 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
